// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared state encoding and timeout counter sizing for the two-master arbiter
package wb_arb_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;
  // At least one bit so a disabled timeout (0) still yields a legal vector.
  function automatic int tmo_width(input int t);
    return t < 1 ? 1 : $clog2(t + 1);
  endfunction
endpackage

// File: rtl/wb_arb_timeout.sv
// wb_arb_timeout: stalled-slave watchdog that forces a one-cycle ack after TIMEOUT unacked stb cycles
module wb_arb_timeout import wb_arb_pkg::*; #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic stb,
  input  logic ack,
  output logic forced_ack
);
  localparam int W = tmo_width(TIMEOUT);
  localparam logic [W-1:0] LAST = W'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  logic [W-1:0] cnt;
  // A real ack in the same cycle always beats the forced one.
  assign forced_ack = (TIMEOUT > 0) && active && stb && !ack && cnt == LAST;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= (!active || !stb || ack || forced_ack) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/wb_mem_arbiter_2m.sv
// wb_mem_arbiter_2m: two-master round-robin wishbone arbiter onto one memory port,
// cycle-granular grants with an IDLE bubble between owners and a stalled-slave timeout.
module wb_mem_arbiter_2m import wb_arb_pkg::*; #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_m0_we,
  input  logic                    i_m0_stb,
  input  logic                    i_m0_cyc,
  input  logic [DATA_WIDTH/8-1:0] i_m0_sel,
  input  logic [ADDR_WIDTH-1:0]   i_m0_adr,
  input  logic [DATA_WIDTH-1:0]   i_m0_dat,
  output logic [DATA_WIDTH-1:0]   o_m0_dat,
  output logic                    o_m0_ack,
  output logic                    o_m0_int,
  input  logic                    i_m1_we,
  input  logic                    i_m1_stb,
  input  logic                    i_m1_cyc,
  input  logic [DATA_WIDTH/8-1:0] i_m1_sel,
  input  logic [ADDR_WIDTH-1:0]   i_m1_adr,
  input  logic [DATA_WIDTH-1:0]   i_m1_dat,
  output logic [DATA_WIDTH-1:0]   o_m1_dat,
  output logic                    o_m1_ack,
  output logic                    o_m1_int,
  output logic                    o_mem_we,
  output logic                    o_mem_stb,
  output logic                    o_mem_cyc,
  output logic [DATA_WIDTH/8-1:0] o_mem_sel,
  output logic [ADDR_WIDTH-1:0]   o_mem_adr,
  output logic [DATA_WIDTH-1:0]   o_mem_dat,
  input  logic [DATA_WIDTH-1:0]   i_mem_dat,
  input  logic                    i_mem_ack,
  input  logic                    i_mem_int,
  output logic [1:0]              o_grant,
  output logic                    o_timeout
);
  logic [1:0] state, nxt;
  logic last_owner, g0, g1, own_stb, forced_ack;
  assign g0 = state == OWN0;
  assign g1 = state == OWN1;
  assign o_grant = state;
  // Owners always return to IDLE first; ties go to whoever did not own last.
  always_comb
    nxt = g0 ? (i_m0_cyc ? OWN0 : IDLE) :
          g1 ? (i_m1_cyc ? OWN1 : IDLE) :
          i_m0_cyc && i_m1_cyc ? (last_owner ? OWN0 : OWN1) :
          i_m0_cyc ? OWN0 : i_m1_cyc ? OWN1 : IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      last_owner <= 1'b1;
    end else begin
      state <= nxt;
      if ((g0 || g1) && nxt == IDLE) last_owner <= g1;
    end
  assign own_stb = g0 ? i_m0_stb : g1 & i_m1_stb;
  wb_arb_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk(clk),
    .rst(rst),
    .active(g0 || g1),
    .stb(own_stb),
    .ack(i_mem_ack),
    .forced_ack(forced_ack)
  );
  assign o_mem_we  = g0 ? i_m0_we  : g1 & i_m1_we;
  assign o_mem_stb = own_stb;
  assign o_mem_cyc = g0 ? i_m0_cyc : g1 & i_m1_cyc;
  assign o_mem_sel = g0 ? i_m0_sel : g1 ? i_m1_sel : '0;
  assign o_mem_adr = g0 ? i_m0_adr : g1 ? i_m1_adr : '0;
  assign o_mem_dat = g0 ? i_m0_dat : g1 ? i_m1_dat : '0;
  assign o_m0_ack  = g0 & (i_mem_ack | forced_ack);
  assign o_m1_ack  = g1 & (i_mem_ack | forced_ack);
  assign o_m0_dat  = g0 && !forced_ack ? i_mem_dat : '0;
  assign o_m1_dat  = g1 && !forced_ack ? i_mem_dat : '0;
  assign o_m0_int  = i_mem_int;
  assign o_m1_int  = i_mem_int;
  assign o_timeout = forced_ack;
endmodule

// File: tb/tb_wb_mem_arbiter_2m.sv
// tb_wb_mem_arbiter_2m: directed scenarios plus randomized traffic checked against an owner-level model
module tb_wb_mem_arbiter_2m;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TMO = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_m0_we, i_m0_stb, i_m0_cyc, i_m1_we, i_m1_stb, i_m1_cyc;
  logic [DW/8-1:0] i_m0_sel, i_m1_sel, o_mem_sel;
  logic [AW-1:0] i_m0_adr, i_m1_adr, o_mem_adr;
  logic [DW-1:0] i_m0_dat, i_m1_dat, o_m0_dat, o_m1_dat, o_mem_dat, i_mem_dat;
  logic o_m0_ack, o_m0_int, o_m1_ack, o_m1_int;
  logic o_mem_we, o_mem_stb, o_mem_cyc, i_mem_ack, i_mem_int, o_timeout;
  logic [1:0] o_grant;
  int checks = 0;
  int errors = 0;
  wb_mem_arbiter_2m #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .i_m0_we(i_m0_we), .i_m0_stb(i_m0_stb), .i_m0_cyc(i_m0_cyc), .i_m0_sel(i_m0_sel),
    .i_m0_adr(i_m0_adr), .i_m0_dat(i_m0_dat), .o_m0_dat(o_m0_dat), .o_m0_ack(o_m0_ack), .o_m0_int(o_m0_int),
    .i_m1_we(i_m1_we), .i_m1_stb(i_m1_stb), .i_m1_cyc(i_m1_cyc), .i_m1_sel(i_m1_sel),
    .i_m1_adr(i_m1_adr), .i_m1_dat(i_m1_dat), .o_m1_dat(o_m1_dat), .o_m1_ack(o_m1_ack), .o_m1_int(o_m1_int),
    .o_mem_we(o_mem_we), .o_mem_stb(o_mem_stb), .o_mem_cyc(o_mem_cyc), .o_mem_sel(o_mem_sel),
    .o_mem_adr(o_mem_adr), .o_mem_dat(o_mem_dat), .i_mem_dat(i_mem_dat), .i_mem_ack(i_mem_ack),
    .i_mem_int(i_mem_int), .o_grant(o_grant), .o_timeout(o_timeout)
  );
  always #5 clk = ~clk;
  // Reference model: who owns the bus (-1 = nobody), who owned it last, and how long the owner has waited.
  int m_own = -1;
  int m_last = 1;
  int m_wait = 0;
  logic m_stb, m_cyc;
  assign m_stb = m_own == 0 ? i_m0_stb : m_own == 1 ? i_m1_stb : 1'b0;
  assign m_cyc = m_own == 0 ? i_m0_cyc : m_own == 1 ? i_m1_cyc : 1'b0;
  always @(posedge clk or posedge rst)
    if (rst) begin
      m_own <= -1;
      m_last <= 1;
      m_wait <= 0;
    end else begin
      m_wait <= (m_own < 0 || !m_stb || i_mem_ack || m_wait == TMO - 1) ? 0 : m_wait + 1;
      if (m_own < 0) m_own <= (i_m0_cyc && i_m1_cyc) ? 1 - m_last : i_m0_cyc ? 0 : i_m1_cyc ? 1 : -1;
      else if (!m_cyc) begin
        m_own <= -1;
        m_last <= m_own;
      end
    end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_inputs();
    {i_m0_we, i_m0_stb, i_m0_cyc, i_m1_we, i_m1_stb, i_m1_cyc} = '0;
    i_m0_sel = '0; i_m1_sel = '0; i_m0_adr = '0; i_m1_adr = '0; i_m0_dat = '0; i_m1_dat = '0;
    i_mem_dat = '0; i_mem_ack = 1'b0; i_mem_int = 1'b0;
  endtask
  task automatic apply_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    rst = 1'b0;
    tick();
  endtask
  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    checks++; if (o_grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b want 00", o_grant); end
    checks++; if (o_mem_cyc !== 1'b0) begin errors++; $display("FAIL reset_mem_cyc: got %b want 0", o_mem_cyc); end
    checks++; if ({o_m1_ack, o_m0_ack} !== 2'b00) begin errors++; $display("FAIL reset_acks: got %b want 00", {o_m1_ack, o_m0_ack}); end
    checks++; if (o_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", o_timeout); end
    tick();
    rst = 1'b0;
    tick();
  endtask
  task automatic test_single();
    i_m0_cyc = 1'b1; i_m0_stb = 1'b1; i_m0_we = 1'b1; i_m0_sel = 4'hF;
    i_m0_adr = 32'h10; i_m0_dat = 32'hA5A5A5A5; i_mem_int = 1'b1;
    @(negedge clk);
    checks++; if (o_grant !== 2'b00) begin errors++; $display("FAIL single_latency: got %b want 00", o_grant); end
    checks++; if ({o_m1_int, o_m0_int} !== 2'b11) begin errors++; $display("FAIL int_bcast: got %b want 11", {o_m1_int, o_m0_int}); end
    tick();
    i_mem_int = 1'b0;
    @(negedge clk);
    checks++; if (o_grant !== 2'b01) begin errors++; $display("FAIL single_grant: got %b want 01", o_grant); end
    checks++; if (o_mem_adr !== 32'h10) begin errors++; $display("FAIL single_adr: got %h want 10", o_mem_adr); end
    checks++; if (o_mem_dat !== 32'hA5A5A5A5) begin errors++; $display("FAIL single_wdat: got %h want a5a5a5a5", o_mem_dat); end
    checks++; if ({o_mem_we, o_mem_stb, o_mem_cyc} !== 3'b111) begin errors++; $display("FAIL single_ctl: got %b want 111", {o_mem_we, o_mem_stb, o_mem_cyc}); end
    checks++; if ({o_m1_int, o_m0_int} !== 2'b00) begin errors++; $display("FAIL int_clear: got %b want 00", {o_m1_int, o_m0_int}); end
    tick();
    @(negedge clk);
    checks++; if (o_m0_ack !== 1'b0) begin errors++; $display("FAIL single_early_ack: got %b want 0", o_m0_ack); end
    tick();
    i_mem_ack = 1'b1; i_mem_dat = 32'h12345678;
    @(negedge clk);
    checks++; if (o_m0_ack !== 1'b1) begin errors++; $display("FAIL single_ack: got %b want 1", o_m0_ack); end
    checks++; if (o_m0_dat !== 32'h12345678) begin errors++; $display("FAIL single_rdat: got %h want 12345678", o_m0_dat); end
    checks++; if ({o_m1_ack, o_m1_dat} !== 33'd0) begin errors++; $display("FAIL single_m1_quiet: got %b/%h want 0/0", o_m1_ack, o_m1_dat); end
    tick();
    idle_inputs();
    @(negedge clk);
    checks++; if (o_grant !== 2'b01) begin errors++; $display("FAIL single_hold: got %b want 01", o_grant); end
    tick();
    @(negedge clk);
    checks++; if (o_grant !== 2'b00) begin errors++; $display("FAIL single_release: got %b want 00", o_grant); end
    checks++; if (o_mem_adr !== 32'h0) begin errors++; $display("FAIL idle_adr: got %h want 0", o_mem_adr); end
  endtask
  task automatic test_round_robin();
    apply_reset();
    i_m0_cyc = 1'b1; i_m1_cyc = 1'b1;
    tick();
    for (int t = 0; t < 6; t++) begin
      int m;
      logic [1:0] eg;
      m = t % 2;
      eg = m == 1 ? 2'b10 : 2'b01;
      for (int k = 0; k < 4; k++) begin
        if (m == 1) begin i_m1_stb = 1'b1; i_m1_adr = 32'(t * 16 + k); end
        else begin i_m0_stb = 1'b1; i_m0_adr = 32'(t * 16 + k); end
        i_mem_ack = 1'b1; i_mem_dat = $urandom;
        @(negedge clk);
        checks++; if (o_grant !== eg) begin errors++; $display("FAIL rr_owner t%0d: got %b want %b", t, o_grant, eg); end
        checks++; if ({o_m1_ack, o_m0_ack} !== eg) begin errors++; $display("FAIL rr_ack t%0d: got %b want %b", t, {o_m1_ack, o_m0_ack}, eg); end
        checks++; if (o_mem_adr !== 32'(t * 16 + k)) begin errors++; $display("FAIL rr_adr t%0d: got %h want %h", t, o_mem_adr, 32'(t * 16 + k)); end
        tick();
      end
      if (m == 1) begin i_m1_cyc = 1'b0; i_m1_stb = 1'b0; end
      else begin i_m0_cyc = 1'b0; i_m0_stb = 1'b0; end
      i_mem_ack = 1'b0;
      @(negedge clk);
      checks++; if (o_grant !== eg) begin errors++; $display("FAIL rr_hold t%0d: got %b want %b", t, o_grant, eg); end
      tick();
      if (t + 2 < 6) begin
        if (m == 1) i_m1_cyc = 1'b1;
        else i_m0_cyc = 1'b1;
      end
      @(negedge clk);
      checks++; if (o_grant !== 2'b00) begin errors++; $display("FAIL rr_bubble t%0d: got %b want 00", t, o_grant); end
      tick();
    end
  endtask
  task automatic test_hold_off();
    i_m1_cyc = 1'b1; i_m1_stb = 1'b1;
    tick();
    i_m0_cyc = 1'b1; i_m0_stb = 1'b1; i_m0_adr = 32'hBEEF;
    for (int k = 0; k < 3; k++) begin
      i_m1_adr = 32'h200 + 32'(k); i_mem_ack = 1'b1;
      @(negedge clk);
      checks++; if (o_grant !== 2'b10) begin errors++; $display("FAIL hold_owner: got %b want 10", o_grant); end
      checks++; if (o_m0_ack !== 1'b0) begin errors++; $display("FAIL hold_m0_ack: got %b want 0", o_m0_ack); end
      checks++; if (o_mem_adr !== 32'h200 + 32'(k)) begin errors++; $display("FAIL hold_adr: got %h want %h", o_mem_adr, 32'h200 + 32'(k)); end
      tick();
    end
    i_m1_cyc = 1'b0; i_m1_stb = 1'b0; i_mem_ack = 1'b0;
    @(negedge clk);
    checks++; if (o_grant !== 2'b10) begin errors++; $display("FAIL hold_release: got %b want 10", o_grant); end
    tick();
    @(negedge clk);
    checks++; if ({o_grant, o_m0_ack} !== 3'b000) begin errors++; $display("FAIL hold_bubble: got %b want 000", {o_grant, o_m0_ack}); end
    tick();
    @(negedge clk);
    checks++; if (o_grant !== 2'b01) begin errors++; $display("FAIL hold_handover: got %b want 01", o_grant); end
    checks++; if (o_mem_adr !== 32'hBEEF) begin errors++; $display("FAIL hold_m0_adr: got %h want beef", o_mem_adr); end
    tick();
    i_mem_ack = 1'b1;
    @(negedge clk);
    checks++; if (o_m0_ack !== 1'b1) begin errors++; $display("FAIL hold_m0_done: got %b want 1", o_m0_ack); end
    tick();
    idle_inputs();
    tick();
    tick();
  endtask
  task automatic test_timeout();
    int hit;
    hit = -1;
    i_m0_cyc = 1'b1; i_m0_stb = 1'b1; i_mem_dat = 32'hDEADBEEF;
    for (int i = 0; i < 20 && hit < 0; i++) begin
      @(negedge clk);
      if (o_timeout) hit = i;
      else begin
        checks++; if (o_m0_ack !== 1'b0) begin errors++; $display("FAIL tmo_early_ack cyc%0d: got %b want 0", i, o_m0_ack); end
      end
      if (hit < 0) tick();
    end
    checks++; if (hit != 8) begin errors++; $display("FAIL tmo_latency: got %0d want 8", hit); end
    checks++; if (o_m0_ack !== 1'b1) begin errors++; $display("FAIL tmo_forced_ack: got %b want 1", o_m0_ack); end
    checks++; if (o_m0_dat !== 32'h0) begin errors++; $display("FAIL tmo_dat: got %h want 0", o_m0_dat); end
    checks++; if (o_grant !== 2'b01) begin errors++; $display("FAIL tmo_grant: got %b want 01", o_grant); end
    tick();
    @(negedge clk);
    checks++; if ({o_grant, o_timeout, o_m0_ack} !== 4'b0100) begin errors++; $display("FAIL tmo_keep: got %b want 0100", {o_grant, o_timeout, o_m0_ack}); end
    for (int i = 0; i < 7; i++) tick();
    i_mem_ack = 1'b1;
    @(negedge clk);
    checks++; if ({o_m0_ack, o_timeout} !== 2'b10) begin errors++; $display("FAIL tmo_real_wins: got %b want 10", {o_m0_ack, o_timeout}); end
    checks++; if (o_m0_dat !== 32'hDEADBEEF) begin errors++; $display("FAIL tmo_real_dat: got %h want deadbeef", o_m0_dat); end
    tick();
    idle_inputs();
    tick();
    tick();
  endtask
  task automatic test_reset_mid();
    i_m1_cyc = 1'b1; i_m1_stb = 1'b1; i_m1_adr = 32'h300;
    tick();
    tick();
    @(negedge clk);
    checks++; if ({o_grant, o_mem_cyc} !== 3'b101) begin errors++; $display("FAIL rst_pre: got %b want 101", {o_grant, o_mem_cyc}); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({o_grant, o_mem_cyc} !== 3'b000) begin errors++; $display("FAIL rst_async: got %b want 000", {o_grant, o_mem_cyc}); end
    tick();
    idle_inputs();
    tick();
    rst = 1'b0;
    i_m0_cyc = 1'b1; i_m1_cyc = 1'b1;
    tick();
    @(negedge clk);
    checks++; if (o_grant !== 2'b01) begin errors++; $display("FAIL rst_tie: got %b want 01", o_grant); end
    tick();
    idle_inputs();
    tick();
    tick();
  endtask
  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      logic fx;
      logic [1:0] eg;
      i_m0_cyc = $urandom_range(0, 3) != 0; i_m0_stb = $urandom_range(0, 3) != 0; i_m0_we = 1'($urandom);
      i_m1_cyc = $urandom_range(0, 3) != 0; i_m1_stb = $urandom_range(0, 3) != 0; i_m1_we = 1'($urandom);
      i_m0_adr = $urandom; i_m1_adr = $urandom; i_m0_dat = $urandom; i_m1_dat = $urandom;
      i_m0_sel = 4'($urandom); i_m1_sel = 4'($urandom);
      i_mem_ack = $urandom_range(0, 3) == 0; i_mem_dat = $urandom;
      @(negedge clk);
      fx = m_own >= 0 && m_stb && !i_mem_ack && m_wait == TMO - 1;
      eg = m_own == 0 ? 2'b01 : m_own == 1 ? 2'b10 : 2'b00;
      checks++; if (o_grant !== eg) begin errors++; $display("FAIL rand_grant n%0d: got %b want %b", n, o_grant, eg); end
      checks++; if ({o_mem_cyc, o_mem_stb} !== {m_cyc, m_stb}) begin errors++; $display("FAIL rand_ctl n%0d: got %b want %b", n, {o_mem_cyc, o_mem_stb}, {m_cyc, m_stb}); end
      checks++; if (o_mem_adr !== (m_own == 0 ? i_m0_adr : m_own == 1 ? i_m1_adr : 32'h0)) begin errors++; $display("FAIL rand_adr n%0d: got %h", n, o_mem_adr); end
      checks++; if ({o_m1_ack, o_m0_ack} !== (eg & {2{i_mem_ack | fx}})) begin errors++; $display("FAIL rand_ack n%0d: got %b want %b", n, {o_m1_ack, o_m0_ack}, eg & {2{i_mem_ack | fx}}); end
      checks++; if (o_timeout !== fx) begin errors++; $display("FAIL rand_timeout n%0d: got %b want %b", n, o_timeout, fx); end
      checks++; if (o_m0_dat !== (m_own == 0 && !fx ? i_mem_dat : 32'h0)) begin errors++; $display("FAIL rand_rdat n%0d: got %h", n, o_m0_dat); end
      tick();
    end
    idle_inputs();
    tick();
    tick();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end
  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_hold_off();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
